// File: rtl/process_sequencer_if.sv
`default_nettype none
// ============================================================================
// process_sequencer_if
// Command handshake, datapath drive/return and status bundle for the sequencer.
// Revision: 1.0
// ============================================================================
interface process_sequencer_if;
  logic       cmd_valid;
  logic [1:0] cmd_b;
  logic       cmd_ready;
  logic       clr;
  logic       f1;
  logic       f0;
  logic       l;
  logic       N;
  logic       r1;
  logic       r0;
  logic       b1;
  logic       b0;
  logic [1:0] level;
  logic       done;
  logic       err;
  logic [7:0] step_count;
  logic [7:0] max_hits;

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_b, clr, f1, f0, l,
    output cmd_ready, N, r1, r0, b1, b0, level, done, err, step_count, max_hits
  );

  // Upstream issuer plus datapath side
  modport master (
    output cmd_valid, cmd_b, clr, f1, f0, l,
    input  cmd_ready, N, r1, r0, b1, b0, level, done, err, step_count, max_hits
  );
endinterface
`default_nettype wire

// File: rtl/process_sequencer.sv
`default_nettype none
// ============================================================================
// process_sequencer
// Drives the level-update datapath one accepted command at a time and tracks
// step/top-level statistics and light faults.
// Revision: 1.0
// ============================================================================
module process_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  process_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [3:0] c_settle = 4'(SETTLE_CYCLES);

  state_t     r_state, w_state_next;
  logic [1:0] r_level, w_level_next;
  logic [1:0] r_b, w_b_next;
  logic [3:0] r_settle, w_settle_next;
  logic       r_err, w_err_next;
  logic [7:0] r_step_count, w_step_count_next;
  logic [7:0] r_max_hits, w_max_hits_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level      <= 2'd0;
      r_b          <= 2'd0;
      r_settle     <= 4'd0;
      r_err        <= 1'b0;
      r_step_count <= 8'd0;
      r_max_hits   <= 8'd0;
    end else begin
      r_level      <= w_level_next;
      r_b          <= w_b_next;
      r_settle     <= w_settle_next;
      r_err        <= w_err_next;
      r_step_count <= w_step_count_next;
      r_max_hits   <= w_max_hits_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_level_next      = r_level;
    w_b_next          = r_b;
    w_settle_next     = r_settle;
    w_err_next        = r_err;
    w_step_count_next = r_step_count;
    w_max_hits_next   = r_max_hits;
    case (r_state)
      ST_IDLE: begin
        // A command takes priority over a simultaneous clear
        if (bus.cmd_valid) begin
          w_b_next      = bus.cmd_b;
          w_settle_next = c_settle;
          w_state_next  = ST_DRIVE;
        end else if (bus.clr) begin
          w_level_next = 2'd0;
        end
      end
      ST_DRIVE: begin
        if (r_settle <= 4'd1) begin
          w_state_next = ST_CAPTURE;
        end else begin
          w_settle_next = r_settle - 4'd1;
        end
      end
      ST_CAPTURE: begin
        if (bus.l) begin
          w_level_next = {bus.f1, bus.f0};
        end else begin
          w_err_next = 1'b1;
        end
        w_state_next = ST_DONE;
      end
      ST_DONE: begin
        if (r_step_count != 8'hFF) begin
          w_step_count_next = r_step_count + 8'd1;
        end
        if ((r_level == 2'd3) && (r_max_hits != 8'hFF)) begin
          w_max_hits_next = r_max_hits + 8'd1;
        end
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign bus.cmd_ready  = (r_state == ST_IDLE);
  assign bus.N          = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign bus.done       = (r_state == ST_DONE);
  assign bus.r1         = r_level[1];
  assign bus.r0         = r_level[0];
  assign bus.b1         = r_b[1];
  assign bus.b0         = r_b[0];
  assign bus.level      = r_level;
  assign bus.err        = r_err;
  assign bus.step_count = r_step_count;
  assign bus.max_hits   = r_max_hits;

endmodule
`default_nettype wire
